stack_seq: RTL and testbench

Push/pull sequencer for the MC6809 PSHS/PSHU/PULS/PULU instructions and interrupt-entry stacking. It sits between the instruction decoder and the register block, and walks the register-mask postbyte. For pushes it reads each register through the register block's left read path and writes it to memory byte-wise. For pulls it reads memory and writes each register back. It drives the register block's stack-pointer `inc_su`/`dec_su` and `write_reg` controls, and owns the memory handshake for the whole stacking sequence.

---
 rtl/stack_seq_pkg.sv | 55 +++++
 rtl/stack_seq_if.sv | 14 +
 rtl/stack_pick.sv | 30 +++
 rtl/stack_seq.sv | 173 +++++++++++++++++
 tb/tb_stack_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack push/pull sequencer: state encoding,
// stack-mask bit positions and the register-block register numbers.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEC,
        ST_WR,
        ST_RD,
        ST_WB,
        ST_DONE
    } state_e;

    localparam logic [2:0] STK_CC = 3'd0;
    localparam logic [2:0] STK_A  = 3'd1;
    localparam logic [2:0] STK_B  = 3'd2;
    localparam logic [2:0] STK_DP = 3'd3;
    localparam logic [2:0] STK_X  = 3'd4;
    localparam logic [2:0] STK_Y  = 3'd5;
    localparam logic [2:0] STK_OS = 3'd6;
    localparam logic [2:0] STK_PC = 3'd7;

    localparam logic [3:0] RN_X  = 4'd1;
    localparam logic [3:0] RN_Y  = 4'd2;
    localparam logic [3:0] RN_U  = 4'd3;
    localparam logic [3:0] RN_S  = 4'd4;
    localparam logic [3:0] RN_PC = 4'd5;
    localparam logic [3:0] RN_A  = 4'd8;
    localparam logic [3:0] RN_B  = 4'd9;
    localparam logic [3:0] RN_CC = 4'd10;
    localparam logic [3:0] RN_DP = 4'd11;

    localparam logic PH_LO = 1'b0;
    localparam logic PH_HI = 1'b1;

    // Bit 6 names the stack that is not being used for this sequence.
    function automatic logic [3:0] stk_rn(input logic [2:0] idx, input logic use_s);
        case (idx)
            STK_CC:  return RN_CC;
            STK_A:   return RN_A;
            STK_B:   return RN_B;
            STK_DP:  return RN_DP;
            STK_X:   return RN_X;
            STK_Y:   return RN_Y;
            STK_OS:  return use_s ? RN_U : RN_S;
            default: return RN_PC;
        endcase
    endfunction

    function automatic logic stk_wide(input logic [2:0] idx);
        return idx[2];
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Byte-wide memory handshake owned by the sequencer for the whole stacking run.
interface stack_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/stack_pick.sv
// Picks the next register from the remaining mask: highest bit for push, lowest for pull.
// Latency: combinational.
// Backpressure: none.
module stack_pick
    import stack_seq_pkg::*;
(
    input  logic [7:0] mask,
    input  logic       push,
    input  logic       use_s,
    output logic [2:0] idx,
    output logic [3:0] rn,
    output logic       wide
);

    always_comb begin
        idx = 3'd0;
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) idx = i[2:0];
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) idx = i[2:0];
            end
        end
        rn   = stk_rn(idx, use_s);
        wide = stk_wide(idx);
    end

endmodule

// File: rtl/stack_seq.sv
// MC6809 push/pull sequencer: walks the postbyte mask and moves registers to/from the stack.
// Latency: push 2 cycles/byte, pull 1 cycle/byte + 1 writeback, +1 per register, +2 per run.
// Backpressure: memory request held stable until mem_ack; start ignored while busy.
module stack_seq
    import stack_seq_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               start,
    input  logic               push,
    input  logic               use_s,
    input  logic [7:0]         postbyte,
    input  logic [15:0]        reg_su,
    input  logic [15:0]        reg_data,
    stack_seq_if.master        mem,
    output logic [3:0]         reg_addr,
    output logic               write_reg,
    output logic [3:0]         write_reg_addr,
    output logic [15:0]        data_w,
    output logic               inc_su,
    output logic               dec_su,
    output logic               su_sel,
    output logic               busy,
    output logic               done
);

    state_e      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic        push_q, push_d;
    logic        su_sel_q, su_sel_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  rn_q, rn_d;
    logic        wide_q, wide_d;
    logic        phase_q, phase_d;
    logic [15:0] hold_q, hold_d;

    logic [2:0]  pk_idx;
    logic [3:0]  pk_rn;
    logic        pk_wide;

    stack_pick u_pick (
        .mask  (mask_q),
        .push  (push_q),
        .use_s (su_sel_q),
        .idx   (pk_idx),
        .rn    (pk_rn),
        .wide  (pk_wide)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        push_d   = push_q;
        su_sel_d = su_sel_q;
        idx_d    = idx_q;
        rn_d     = rn_q;
        wide_d   = wide_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d   = postbyte;
                    push_d   = push;
                    su_sel_d = use_s;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mask_q == 8'h00) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = pk_idx;
                    rn_d    = pk_rn;
                    wide_d  = pk_wide;
                    // Memory is big-endian, so pushes emit LO first (higher address).
                    phase_d = (push_q || !pk_wide) ? PH_LO : PH_HI;
                    hold_d  = 16'h0000;
                    state_d = push_q ? ST_DEC : ST_RD;
                end
            end
            ST_DEC: state_d = ST_WR;
            ST_WR: begin
                if (mem.mem_ack) begin
                    if (wide_q && phase_q == PH_LO) begin
                        phase_d = PH_HI;
                        state_d = ST_DEC;
                    end else begin
                        mask_d[idx_q] = 1'b0;
                        state_d       = ST_SCAN;
                    end
                end
            end
            ST_RD: begin
                if (mem.mem_ack) begin
                    if (phase_q == PH_HI) hold_d[15:8] = mem.mem_rdata;
                    else                  hold_d[7:0]  = mem.mem_rdata;
                    if (wide_q && phase_q == PH_HI) phase_d = PH_LO;
                    else                            state_d = ST_WB;
                end
            end
            ST_WB: begin
                mask_d[idx_q] = 1'b0;
                state_d       = ST_SCAN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mask_q   <= 8'h00;
            push_q   <= 1'b0;
            su_sel_q <= 1'b0;
            idx_q    <= 3'd0;
            rn_q     <= 4'd0;
            wide_q   <= 1'b0;
            phase_q  <= PH_LO;
            hold_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            push_q   <= push_d;
            su_sel_q <= su_sel_d;
            idx_q    <= idx_d;
            rn_q     <= rn_d;
            wide_q   <= wide_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        reg_addr       = 4'd0;
        write_reg      = 1'b0;
        write_reg_addr = 4'd0;
        data_w         = 16'h0000;
        inc_su         = 1'b0;
        dec_su         = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = 16'h0000;
        mem.mem_wdata  = 8'h00;
        done           = 1'b0;
        su_sel         = su_sel_q;
        busy           = (state_q != ST_IDLE);
        case (state_q)
            ST_DEC: dec_su = 1'b1;
            ST_WR: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = reg_su;
                mem.mem_wdata = (phase_q == PH_HI) ? reg_data[15:8] : reg_data[7:0];
                reg_addr      = rn_q;
            end
            ST_RD: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = reg_su;
                inc_su       = mem.mem_ack;
            end
            ST_WB: begin
                write_reg      = 1'b1;
                write_reg_addr = rn_q;
                data_w         = wide_q ? hold_q : {8'h00, hold_q[7:0]};
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: register-block and memory models around the DUT,
// checked against a byte-level stack model computed from the register mask.
module tb_stack_seq;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        push   = 1'b0;
    logic        use_s  = 1'b0;
    logic [7:0]  postbyte = 8'h00;
    logic [15:0] reg_su, reg_data;
    logic [3:0]  reg_addr, write_reg_addr;
    logic        write_reg, inc_su, dec_su, su_sel, busy, done;
    logic [15:0] data_w;

    stack_seq_if mif ();

    stack_seq dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .start          (start),
        .push           (push),
        .use_s          (use_s),
        .postbyte       (postbyte),
        .reg_su         (reg_su),
        .reg_data       (reg_data),
        .mem            (mif),
        .reg_addr       (reg_addr),
        .write_reg      (write_reg),
        .write_reg_addr (write_reg_addr),
        .data_w         (data_w),
        .inc_su         (inc_su),
        .dec_su         (dec_su),
        .su_sel         (su_sel),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk_in = ~clk_in;

    // Environment: register block and byte memory
    logic [15:0] regs    [16];
    logic [15:0] ld_regs [16];
    logic        ld_req = 1'b0;
    logic [7:0]  mem     [65536];
    logic [23:0] wlog    [$];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic [3:0]  sp_idx;

    assign sp_idx        = su_sel ? 4'd4 : 4'd3;
    assign reg_su        = regs[sp_idx];
    assign reg_data      = regs[reg_addr];
    assign mif.mem_ack   = mif.mem_req && (wait_cnt == wait_cfg);
    assign mif.mem_rdata = mem[mif.mem_addr];

    always @(posedge clk_in) begin
        if (ld_req) begin
            for (int i = 0; i < 16; i++) regs[i] <= ld_regs[i];
        end else begin
            if (dec_su)    regs[sp_idx] <= reg_su - 16'd1;
            if (inc_su)    regs[sp_idx] <= reg_su + 16'd1;
            if (write_reg) regs[write_reg_addr] <= data_w;
        end
        if (mif.mem_req && !mif.mem_ack) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
        if (mif.mem_req && mif.mem_we && mif.mem_ack) begin
            mem[mif.mem_addr] <= mif.mem_wdata;
            wlog.push_back({mif.mem_addr, mif.mem_wdata});
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: what the stack should look like after the run
    logic [15:0] e_regs [16];
    logic [23:0] e_wr   [$];
    int          e_cyc;

    function automatic logic [3:0] rn_of(input int i, input logic us);
        case (i)
            0: return 4'd10;
            1: return 4'd8;
            2: return 4'd9;
            3: return 4'd11;
            4: return 4'd1;
            5: return 4'd2;
            6: return us ? 4'd3 : 4'd4;
            default: return 4'd5;
        endcase
    endfunction

    task automatic model(input logic p, input logic us, input logic [7:0] pb, input int w);
        logic [15:0] sp, v;
        logic [3:0]  spi, rn;
        for (int i = 0; i < 16; i++) e_regs[i] = regs[i];
        e_wr.delete();
        e_cyc = 2;
        spi = us ? 4'd4 : 4'd3;
        sp  = e_regs[spi];
        if (p) begin
            for (int i = 7; i >= 0; i--) begin
                if (pb[i]) begin
                    rn = rn_of(i, us);
                    v  = e_regs[rn];
                    e_cyc += 1;
                    sp = sp - 16'd1; e_wr.push_back({sp, v[7:0]}); e_cyc += 2 + w;
                    if (i >= 4) begin
                        sp = sp - 16'd1; e_wr.push_back({sp, v[15:8]}); e_cyc += 2 + w;
                    end
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pb[i]) begin
                    rn = rn_of(i, us);
                    e_cyc += 2;
                    if (i >= 4) begin
                        v[15:8] = mem[sp]; sp = sp + 16'd1;
                        v[7:0]  = mem[sp]; sp = sp + 16'd1;
                        e_cyc += 2 + 2 * w;
                    end else begin
                        v = {8'h00, mem[sp]}; sp = sp + 16'd1;
                        e_cyc += 1 + w;
                    end
                    e_regs[rn] = v;
                end
            end
        end
        e_regs[spi] = sp;
    endtask

    task automatic load_regs();
        ld_req = 1'b1;
        @(negedge clk_in);
        ld_req = 1'b0;
    endtask

    task automatic snap_regs();
        for (int i = 0; i < 16; i++) ld_regs[i] = regs[i];
    endtask

    task automatic run(input string tag, input logic p, input logic us, input logic [7:0] pb,
                       input int w, input bit poke);
        int cyc, nreq, nbusy_lo, ws, stab_bad, nw;
        bit pend;
        logic [25:0] sv;
        wait_cfg = w;
        model(p, us, pb, w);
        ws = wlog.size();
        nreq = 0; nbusy_lo = 0; stab_bad = 0; pend = 0; sv = '0; cyc = 0;
        push = p; use_s = us; postbyte = pb; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        while (1) begin
            cyc++;
            if (!busy) nbusy_lo++;
            if (mif.mem_req) nreq++;
            if (pend && ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== sv)) stab_bad++;
            pend = mif.mem_req && !mif.mem_ack;
            sv   = {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata};
            if (done || cyc >= 600) break;
            if (poke && cyc == 3) begin
                start = 1'b1; postbyte = ~pb; push = ~p; use_s = ~us;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_in);
        end
        start = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " cycles"}, cyc, e_cyc);
        chk({tag, " busy"}, nbusy_lo, 0);
        chk({tag, " stable"}, stab_bad, 0);
        if (pb == 8'h00) chk({tag, " noreq"}, nreq, 0);
        @(negedge clk_in);
        chk({tag, " done pulse"}, {busy, done}, 0);
        nw = wlog.size() - ws;
        chk({tag, " nwr"}, nw, e_wr.size());
        for (int i = 0; i < nw && i < e_wr.size(); i++)
            chk($sformatf("%s wr%0d", tag, i), wlog[ws + i], e_wr[i]);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s r%0d", tag, i), regs[i], e_regs[i]);
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        chk("rst bus", {mif.mem_addr, mif.mem_wdata, reg_addr, write_reg_addr}, 0);
        chk("rst ctl", {data_w, write_reg, inc_su, dec_su, su_sel, mif.mem_req, mif.mem_we, busy, done}, 0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // PSHS A,B then PULS A,B
        snap_regs();
        ld_regs[4] = 16'h0F00; ld_regs[3] = 16'h2000;
        ld_regs[8] = 16'h0012; ld_regs[9] = 16'h0034;
        load_regs();
        run("pshs06", 1'b1, 1'b1, 8'h06, 0, 1'b0);
        chk("pshs06 m0EFF", mem[16'h0EFF], 8'h34);
        chk("pshs06 m0EFE", mem[16'h0EFE], 8'h12);
        chk("pshs06 S", regs[4], 16'h0EFE);
        snap_regs(); ld_regs[8] = 16'h0; ld_regs[9] = 16'h0; load_regs();
        run("puls06", 1'b0, 1'b1, 8'h06, 0, 1'b0);
        chk("puls06 A", regs[8], 16'h0012);
        chk("puls06 B", regs[9], 16'h0034);
        chk("puls06 S", regs[4], 16'h0F00);

        // PC round trip
        snap_regs(); ld_regs[5] = 16'h1234; load_regs();
        run("pshs80", 1'b1, 1'b1, 8'h80, 0, 1'b0);
        chk("pshs80 m0EFF", mem[16'h0EFF], 8'h34);
        chk("pshs80 m0EFE", mem[16'h0EFE], 8'h12);
        snap_regs(); ld_regs[5] = 16'h0; load_regs();
        run("puls80", 1'b0, 1'b1, 8'h80, 0, 1'b0);
        chk("puls80 PC", regs[5], 16'h1234);

        // Full push, then again with slow memory and a stray start
        snap_regs();
        ld_regs[4] = 16'h0F00; ld_regs[3] = 16'hA55A; ld_regs[1] = 16'h1111;
        ld_regs[2] = 16'h2222; ld_regs[10] = 16'h00D4; ld_regs[11] = 16'h0077;
        load_regs();
        run("pshsFF", 1'b1, 1'b1, 8'hFF, 0, 1'b0);
        chk("pshsFF CC", mem[16'h0EF4], 8'hD4);
        chk("pshsFF S", regs[4], 16'h0EF4);
        snap_regs(); ld_regs[4] = 16'h0F00; load_regs();
        run("pshsFF wait", 1'b1, 1'b1, 8'hFF, 3, 1'b1);
        run("pulsFF wait", 1'b0, 1'b1, 8'hFF, 3, 1'b1);

        run("pb00", 1'b1, 1'b1, 8'h00, 0, 1'b0);

        // Reset in the middle of a push
        push = 1'b1; use_s = 1'b1; postbyte = 8'hFF; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (4) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        chk("midrst bus", {mif.mem_addr, mif.mem_wdata, reg_addr, write_reg_addr}, 0);
        chk("midrst ctl", {data_w, write_reg, inc_su, dec_su, su_sel, mif.mem_req, mif.mem_we, busy, done}, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        run("post rst", 1'b0, 1'b0, 8'h00, 0, 1'b0);

        // Random push/pull traffic
        for (int t = 0; t < 30; t++) begin
            logic p, us;
            logic [7:0] pb;
            int w;
            p  = 1'($urandom_range(0, 1));
            us = 1'($urandom_range(0, 1));
            pb = 8'($urandom_range(0, 255));
            w  = $urandom_range(0, 2);
            snap_regs();
            for (int i = 1; i < 6; i++) ld_regs[i] = 16'($urandom);
            for (int i = 8; i < 12; i++) ld_regs[i] = {8'h00, 8'($urandom)};
            load_regs();
            run($sformatf("rnd%0d", t), p, us, pb, w, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
